i2c_xfer_sched: RTL and testbench
=================================

// Module: i2c_xfer_sched
// PURPOSE
//  Round-robin scheduler sharing one I2C_intrf master between N_REQ requesters
//  (e.g. slow-control register path, periodic PROM/monitor poller). Owns the
//  register-load port of I2C_intrf (DEV_SEL/LOAD_N_BYTE/LOAD_ADDR/WRT_*/EXECUTE).
//  Sequences each transfer, streams readback bytes to the granted requester and
//  reports NACK/timeout. Runs on CLK40; I2C_intrf status arrives from CLK1MHZ logic.
// PARAMETERS
//  N_REQ       2        number of requesters (1..4)
//  TMO_CYC     200000   CLK40 cycles allowed from EXECUTE to READY return (5 ms)
// PORTS
//  CLK40        in   1        sole clock
//  RST_N        in   1        asynchronous, active-low reset
//  REQ          in   N_REQ    level request; hold until DONE pulse while granted
//  REQ_RD       in   N_REQ    1=read, 0=write
//  REQ_NBYTE    in   4*N_REQ  byte count per requester; 0 means 16
//  REQ_ADDR     in   8*N_REQ  register/word address sent after device byte
//  REQ_WDATA    in   8*N_REQ  write byte for index WR_IDX (comb. from requester)
//  GNT          out  N_REQ    one-hot grant, held IDLE->DONE inclusive
//  WR_IDX       out  4        byte index being fetched from granted requester
//  RD_DATA      out  8        readback byte
//  RD_VLD       out  1        1-cycle strobe, RD_DATA valid
//  DONE         out  1        1-cycle end-of-transfer strobe
//  NACK         out  1        status with DONE: slave NACK seen
//  TMO          out  1        status with DONE: READY never returned
//  DEV_SEL, LOAD_N_BYTE, LOAD_ADDR, WRT_ENA, EXECUTE  out 1  to I2C_intrf
//  WRT_ADDR     out  4        to I2C_intrf
//  WRT_DATA     out  8        to I2C_intrf
//  READY, S_NACK in  1        from I2C_intrf (CLK1MHZ domain, synchronise)
//  RBK_WE       in   1        from I2C_intrf (CLK40 25 ns strobe)
//  RBK_DATA     in   8        from I2C_intrf (quasi-static, sample on RBK_WE)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, timer 0.
//  READY, S_NACK pass 2-FF synchronisers -> rdy_s, nack_s.
//  States:
//   IDLE : if |REQ and rdy_s -> pick first requester at/after rr pointer; GNT set
//          next cycle; pointer <= winner+1 (mod N_REQ) -> LD_NB.
//   LD_NB: 1 cyc DEV_SEL=1,LOAD_N_BYTE=1,WRT_DATA={nbyte,rd,3'b000} -> LD_ADR.
//   LD_ADR: 1 cyc DEV_SEL=1,LOAD_ADDR=1,WRT_DATA=addr. Read -> EXEC; write -> LD_DAT.
//   LD_DAT: DEV_SEL=1,WRT_ENA=1,WRT_ADDR=WR_IDX,WRT_DATA=REQ_WDATA[winner];
//          WR_IDX 0..n-1, one byte/cycle (n=16 when NBYTE=0); last -> EXEC.
//   EXEC : DEV_SEL=1,EXECUTE=1 held until rdy_s==0 -> BUSY (>=1 CLK1MHZ edge seen).
//   BUSY : DEV_SEL=0. On RBK_WE: latch RBK_DATA, RD_VLD next cycle (reads only).
//          rdy_s rising -> DONE.
//   DONE : 1 cyc DONE=1, NACK=nack_s, TMO=0; drop GNT -> IDLE.
//  Timer: cleared entering EXEC, counts in EXEC/BUSY; reaching TMO_CYC-1 forces
//   DONE with TMO=1,NACK=0; IDLE then blocks new grants until rdy_s==1.
//  WR_IDX is 4 bits; 16-byte write wraps 15->0 only on leaving LD_DAT.
//  Requester dropping REQ while granted: ignored, transfer completes.
//  Simultaneous REQ: rr order; equal priority after each grant.
//  RBK_WE outside BUSY: ignored, no RD_VLD.
//  RST_N low mid-transfer: immediate return to reset values; I2C_intrf is reset
//   by the same system reset so no bus cleanup here.
// STRUCTURE
//  Shared header i2c_sched_defs: state encodings, NBYTE_ALL16 constant,
//   WRT_DATA field offsets of the n-byte word.
//  Sub-module sync_2ff (generic 2-flop synchroniser), two instances.
//  FSM, rr arbiter, byte counter, timer in this module.
// TESTING
//  Bus model of I2C_intrf (READY drops 3 us after EXECUTE, RBK_WE per byte).
//  Req0 write n=2 addr 0x10 data A5,5A -> LOAD_N_BYTE WRT_DATA=0x20, LOAD_ADDR 0x10,
//   WRT_ADDR 0/1 = A5/5A, EXECUTE until READY low, DONE NACK=0.
//  Req1 read n=3 addr 0x40, model returns 11,22,33 -> three RD_VLD with 11,22,33,
//   LOAD_N_BYTE WRT_DATA=0x38, DONE after READY high.
//  REQ=2'b11 held continuously -> grants alternate 0,1,0,1; none lost or doubled.
//  NBYTE=0 write -> 16 WRT_ENA cycles WRT_ADDR 0..15, WRT_DATA field =0x00.
//  Model holds READY low forever -> DONE with TMO=1 at TMO_CYC; next REQ not
//   granted until READY returns.
//  Model S_NACK=1 -> DONE with NACK=1; RST_N pulsed in LD_DAT -> all outputs 0.

Source files
------------

// File: rtl/i2c_xfer_sched_pkg.sv
// Shared definitions for the I2C transfer scheduler:
// FSM encodings and the n-byte load word layout.
package i2c_sched_defs;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_NB,
        S_LD_ADR,
        S_LD_DAT,
        S_EXEC,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [3:0] NBYTE_ALL16 = 4'd0;
    localparam int NB_LSB = 4;
    localparam int RD_BIT = 3;

    function automatic logic [7:0] nbyte_word(input logic [3:0] nb, input logic rd);
        logic [7:0] w;
        w = '0;
        w[NB_LSB +: 4] = nb;
        w[RD_BIT] = rd;
        return w;
    endfunction

endpackage

// File: rtl/i2c_xfer_sched_sync.sv
// Generic two-flop synchroniser for single-bit status
// crossing into the CLK40 domain.
module sync_2ff (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic Q
);

    logic meta;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= 1'b0;
            Q    <= 1'b0;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/i2c_xfer_sched.sv
// Round-robin scheduler sharing one I2C_intrf master
// between N_REQ requesters on CLK40.
module i2c_xfer_sched
    import i2c_sched_defs::*;
#(
    parameter int N_REQ   = 2,
    parameter int TMO_CYC = 200000
) (
    input  logic               CLK40,
    input  logic               RST_N,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [N_REQ-1:0]   REQ_RD,
    input  logic [4*N_REQ-1:0] REQ_NBYTE,
    input  logic [8*N_REQ-1:0] REQ_ADDR,
    input  logic [8*N_REQ-1:0] REQ_WDATA,
    output logic [N_REQ-1:0]   GNT,
    output logic [3:0]         WR_IDX,
    output logic [7:0]         RD_DATA,
    output logic               RD_VLD,
    output logic               DONE,
    output logic               NACK,
    output logic               TMO,
    output logic               DEV_SEL,
    output logic               LOAD_N_BYTE,
    output logic               LOAD_ADDR,
    output logic               WRT_ENA,
    output logic               EXECUTE,
    output logic [3:0]         WRT_ADDR,
    output logic [7:0]         WRT_DATA,
    input  logic               READY,
    input  logic               S_NACK,
    input  logic               RBK_WE,
    input  logic [7:0]         RBK_DATA
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          cur_rd;
    logic [3:0]    cur_last;
    logic [TW-1:0] timer;
    logic          rdy_s;
    logic          nack_s;

    sync_2ff u_sync_rdy (
        .CLK   (CLK40),
        .RST_N (RST_N),
        .D     (READY),
        .Q     (rdy_s)
    );

    sync_2ff u_sync_nack (
        .CLK   (CLK40),
        .RST_N (RST_N),
        .D     (S_NACK),
        .Q     (nack_s)
    );

    // First requesting index at or after ptr wins.
    logic             hit;
    logic [PW-1:0]    pick;
    logic [N_REQ-1:0] pick_oh;

    always_comb begin
        int idx;
        hit     = 1'b0;
        pick    = '0;
        pick_oh = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (REQ[idx]) begin
                hit          = 1'b1;
                pick         = PW'(idx);
                pick_oh      = '0;
                pick_oh[idx] = 1'b1;
            end
        end
    end

    logic [3:0] pick_nb;
    logic       pick_rd;
    logic [7:0] win_addr;
    logic [7:0] win_wdata;

    assign pick_nb   = REQ_NBYTE[int'(pick)*4 +: 4];
    assign pick_rd   = REQ_RD[pick];
    assign win_addr  = REQ_ADDR[int'(win)*8 +: 8];
    assign win_wdata = REQ_WDATA[int'(win)*8 +: 8];

    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            ptr         <= '0;
            win         <= '0;
            cur_rd      <= 1'b0;
            cur_last    <= '0;
            timer       <= '0;
            GNT         <= '0;
            WR_IDX      <= '0;
            RD_DATA     <= '0;
            RD_VLD      <= 1'b0;
            DONE        <= 1'b0;
            NACK        <= 1'b0;
            TMO         <= 1'b0;
            DEV_SEL     <= 1'b0;
            LOAD_N_BYTE <= 1'b0;
            LOAD_ADDR   <= 1'b0;
            WRT_ENA     <= 1'b0;
            EXECUTE     <= 1'b0;
            WRT_ADDR    <= '0;
            WRT_DATA    <= '0;
        end else begin
            RD_VLD <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // rdy_s gate also holds off grants after a timeout.
                    if (hit && rdy_s) begin
                        GNT         <= pick_oh;
                        win         <= pick;
                        ptr         <= (int'(pick) == N_REQ - 1) ? '0 : pick + 1'b1;
                        cur_rd      <= pick_rd;
                        cur_last    <= (pick_nb == NBYTE_ALL16) ? 4'd15 : pick_nb - 4'd1;
                        DEV_SEL     <= 1'b1;
                        LOAD_N_BYTE <= 1'b1;
                        WRT_DATA    <= nbyte_word(pick_nb, pick_rd);
                        state       <= S_LD_NB;
                    end
                end
                S_LD_NB: begin
                    LOAD_N_BYTE <= 1'b0;
                    LOAD_ADDR   <= 1'b1;
                    WRT_DATA    <= win_addr;
                    state       <= S_LD_ADR;
                end
                S_LD_ADR: begin
                    LOAD_ADDR <= 1'b0;
                    if (cur_rd) begin
                        EXECUTE <= 1'b1;
                        timer   <= '0;
                        state   <= S_EXEC;
                    end else begin
                        WRT_ENA  <= 1'b1;
                        WRT_ADDR <= WR_IDX;
                        WRT_DATA <= win_wdata;
                        if (WR_IDX != cur_last) WR_IDX <= WR_IDX + 4'd1;
                        state    <= S_LD_DAT;
                    end
                end
                S_LD_DAT: begin
                    // WR_IDX runs one byte ahead of WRT_ADDR.
                    if (WRT_ADDR == cur_last) begin
                        WRT_ENA <= 1'b0;
                        WR_IDX  <= '0;
                        EXECUTE <= 1'b1;
                        timer   <= '0;
                        state   <= S_EXEC;
                    end else begin
                        WRT_ADDR <= WR_IDX;
                        WRT_DATA <= win_wdata;
                        if (WR_IDX != cur_last) WR_IDX <= WR_IDX + 4'd1;
                    end
                end
                S_EXEC: begin
                    if (timer == TMO_LAST) begin
                        EXECUTE <= 1'b0;
                        DEV_SEL <= 1'b0;
                        DONE    <= 1'b1;
                        TMO     <= 1'b1;
                        NACK    <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                        if (!rdy_s) begin
                            EXECUTE <= 1'b0;
                            DEV_SEL <= 1'b0;
                            state   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (RBK_WE) begin
                        RD_DATA <= RBK_DATA;
                        RD_VLD  <= cur_rd;
                    end
                    if (timer == TMO_LAST) begin
                        DONE  <= 1'b1;
                        TMO   <= 1'b1;
                        NACK  <= 1'b0;
                        state <= S_DONE;
                    end else if (rdy_s) begin
                        DONE  <= 1'b1;
                        TMO   <= 1'b0;
                        NACK  <= nack_s;
                        state <= S_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DONE: begin
                    DONE  <= 1'b0;
                    NACK  <= 1'b0;
                    TMO   <= 1'b0;
                    GNT   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xfer_sched.sv
// Directed bench for i2c_xfer_sched with a simple
// behavioural model of I2C_intrf.
module tb_i2c_xfer_sched;

    localparam int N   = 2;
    localparam int TMO = 1000;

    logic         CLK40 = 1'b0;
    logic         RST_N = 1'b0;
    logic [1:0]   REQ = '0;
    logic [1:0]   REQ_RD = '0;
    logic [7:0]   REQ_NBYTE = '0;
    logic [15:0]  REQ_ADDR = '0;
    logic [15:0]  REQ_WDATA;
    logic [1:0]   GNT;
    logic [3:0]   WR_IDX;
    logic [7:0]   RD_DATA;
    logic         RD_VLD, DONE, NACK, TMO_O;
    logic         DEV_SEL, LOAD_N_BYTE, LOAD_ADDR, WRT_ENA, EXECUTE;
    logic [3:0]   WRT_ADDR;
    logic [7:0]   WRT_DATA;
    logic         READY = 1'b1;
    logic         S_NACK = 1'b0;
    logic         RBK_WE = 1'b0;
    logic [7:0]   RBK_DATA = '0;

    i2c_xfer_sched #(.N_REQ(N), .TMO_CYC(TMO)) dut (
        .CLK40(CLK40), .RST_N(RST_N), .REQ(REQ), .REQ_RD(REQ_RD),
        .REQ_NBYTE(REQ_NBYTE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .GNT(GNT), .WR_IDX(WR_IDX), .RD_DATA(RD_DATA), .RD_VLD(RD_VLD),
        .DONE(DONE), .NACK(NACK), .TMO(TMO_O), .DEV_SEL(DEV_SEL),
        .LOAD_N_BYTE(LOAD_N_BYTE), .LOAD_ADDR(LOAD_ADDR), .WRT_ENA(WRT_ENA),
        .EXECUTE(EXECUTE), .WRT_ADDR(WRT_ADDR), .WRT_DATA(WRT_DATA),
        .READY(READY), .S_NACK(S_NACK), .RBK_WE(RBK_WE), .RBK_DATA(RBK_DATA)
    );

    always #12.5 CLK40 = ~CLK40;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge CLK40) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Requester write-data sources, indexed combinationally by WR_IDX.
    logic [7:0] w0 [16];
    logic [7:0] w1 [16];
    always_comb REQ_WDATA = {w1[WR_IDX], w0[WR_IDX]};

    // I2C_intrf model.
    logic       m_nack = 1'b0;
    logic       m_hang = 1'b0;
    int         m_nrd = 0;
    logic [7:0] m_rd [16];

    initial begin
        forever begin
            @(negedge CLK40);
            if (EXECUTE) begin
                repeat (120) @(negedge CLK40);
                READY  = 1'b0;
                S_NACK = m_nack;
                if (m_hang) begin
                    while (m_hang) @(negedge CLK40);
                end else begin
                    repeat (40) @(negedge CLK40);
                    for (int i = 0; i < m_nrd; i++) begin
                        RBK_DATA = m_rd[i];
                        RBK_WE   = 1'b1;
                        @(negedge CLK40);
                        RBK_WE   = 1'b0;
                        repeat (20) @(negedge CLK40);
                    end
                    repeat (40) @(negedge CLK40);
                end
                READY = 1'b1;
            end
        end
    end

    // Bus log.
    logic [7:0] nb_word, adr_word;
    logic [3:0] wq_a [$];
    logic [7:0] wq_d [$];
    logic [7:0] rq [$];
    int         ex_cnt, ex_t0;
    logic       ex_prev = 1'b0;

    always @(negedge CLK40) begin
        if (RST_N) begin
            if (LOAD_N_BYTE) nb_word = WRT_DATA;
            if (LOAD_ADDR) adr_word = WRT_DATA;
            if (WRT_ENA) begin
                wq_a.push_back(WRT_ADDR);
                wq_d.push_back(WRT_DATA);
            end
            if (RD_VLD) rq.push_back(RD_DATA);
            if (EXECUTE) begin
                if (!ex_prev) ex_t0 = cyc;
                ex_cnt++;
            end
        end
        ex_prev = EXECUTE;
    end

    task automatic clr_log();
        nb_word  = 8'hxx;
        adr_word = 8'hxx;
        wq_a.delete();
        wq_d.delete();
        rq.delete();
        ex_cnt = 0;
    endtask

    task automatic start(input int idx, input logic rd, input logic [3:0] nb,
                         input logic [7:0] addr);
        REQ_RD[idx]          = rd;
        REQ_NBYTE[idx*4 +: 4] = nb;
        REQ_ADDR[idx*8 +: 8]  = addr;
        REQ[idx]             = 1'b1;
    endtask

    logic [1:0] d_gnt;
    logic       d_nack, d_tmo;
    int         d_cyc;

    task automatic wait_done(input string tag, input int maxc);
        bit ok;
        ok     = 1'b0;
        d_gnt  = 'x;
        d_nack = 1'bx;
        d_tmo  = 1'bx;
        for (int i = 0; i < maxc; i++) begin
            @(negedge CLK40);
            if (DONE) begin
                ok     = 1'b1;
                d_gnt  = GNT;
                d_nack = NACK;
                d_tmo  = TMO_O;
                d_cyc  = cyc;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    function automatic logic [63:0] outs();
        return 64'({GNT, WR_IDX, RD_DATA, RD_VLD, DONE, NACK, TMO_O, DEV_SEL,
                    LOAD_N_BYTE, LOAD_ADDR, WRT_ENA, EXECUTE, WRT_ADDR, WRT_DATA});
    endfunction

    initial begin
        int sz;
        bit seq_ok;
        logic [1:0] g[4];
        for (int i = 0; i < 16; i++) begin
            w0[i] = '0;
            w1[i] = '0;
            m_rd[i] = '0;
        end
        clr_log();

        repeat (3) @(negedge CLK40);
        check("reset_outs", outs(), 64'd0);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK40);
        check("idle_outs", outs(), 64'd0);

        // Write n=2 from requester 0.
        clr_log();
        w0[0] = 8'hA5;
        w0[1] = 8'h5A;
        m_nrd = 0;
        start(0, 1'b0, 4'd2, 8'h10);
        wait_done("wr2_done", 3000);
        REQ[0] = 1'b0;
        check("wr2_nbword", 64'(nb_word), 64'h20);
        check("wr2_addr", 64'(adr_word), 64'h10);
        check("wr2_cnt", 64'(wq_a.size()), 64'd2);
        if (wq_a.size() == 2) begin
            check("wr2_b0", 64'({wq_a[0], wq_d[0]}), 64'h0A5);
            check("wr2_b1", 64'({wq_a[1], wq_d[1]}), 64'h15A);
        end
        check("wr2_exec_len", 64'(ex_cnt >= 121 && ex_cnt <= 125), 64'd1);
        check("wr2_status", 64'({d_gnt, d_nack, d_tmo}), 64'b0100);
        @(negedge CLK40);
        check("wr2_gnt_drop", 64'(GNT), 64'd0);

        // Readback strobe while idle must be ignored.
        sz = rq.size();
        RBK_DATA = 8'hEE;
        RBK_WE = 1'b1;
        @(negedge CLK40);
        RBK_WE = 1'b0;
        repeat (3) @(negedge CLK40);
        check("rbk_idle", 64'(rq.size()), 64'(sz));

        // Read n=3 from requester 1.
        clr_log();
        m_rd[0] = 8'h11;
        m_rd[1] = 8'h22;
        m_rd[2] = 8'h33;
        m_nrd = 3;
        start(1, 1'b1, 4'd3, 8'h40);
        wait_done("rd3_done", 3000);
        REQ[1] = 1'b0;
        m_nrd = 0;
        check("rd3_nbword", 64'(nb_word), 64'h38);
        check("rd3_addr", 64'(adr_word), 64'h40);
        check("rd3_nwr", 64'(wq_a.size()), 64'd0);
        check("rd3_cnt", 64'(rq.size()), 64'd3);
        if (rq.size() == 3) check("rd3_data", 64'({rq[0], rq[1], rq[2]}), 64'h112233);
        check("rd3_status", 64'({d_gnt, d_nack, d_tmo}), 64'b1000);

        // Both requesting continuously: grants alternate.
        start(0, 1'b0, 4'd1, 8'h01);
        start(1, 1'b0, 4'd1, 8'h02);
        for (int k = 0; k < 4; k++) begin
            wait_done("rr_done", 3000);
            g[k] = d_gnt;
            if (k == 3) REQ = 2'b00;
        end
        check("rr_seq", 64'({g[0], g[1], g[2], g[3]}), 64'b01100110);
        @(negedge CLK40);

        // NBYTE=0 means 16 bytes.
        clr_log();
        for (int i = 0; i < 16; i++) w0[i] = 8'(i * 17 + 3);
        start(0, 1'b0, 4'd0, 8'h77);
        wait_done("wr16_done", 4000);
        REQ[0] = 1'b0;
        check("wr16_nbword", 64'(nb_word), 64'h00);
        check("wr16_cnt", 64'(wq_a.size()), 64'd16);
        seq_ok = (wq_a.size() == 16);
        for (int i = 0; i < 16 && seq_ok; i++)
            if (wq_a[i] != 4'(i) || wq_d[i] != 8'(i * 17 + 3)) seq_ok = 1'b0;
        check("wr16_seq", 64'(seq_ok), 64'd1);
        check("wr16_idx0", 64'(WR_IDX), 64'd0);

        // READY never returns: timeout, then grants wait for READY.
        clr_log();
        m_hang = 1'b1;
        start(0, 1'b0, 4'd1, 8'h55);
        wait_done("tmo_done", 3000);
        REQ[0] = 1'b0;
        check("tmo_status", 64'({d_nack, d_tmo}), 64'b01);
        check("tmo_cycles", 64'(d_cyc - ex_t0), 64'(TMO));
        clr_log();
        m_rd[0] = 8'h77;
        m_nrd = 1;
        start(1, 1'b1, 4'd1, 8'h66);
        repeat (200) @(negedge CLK40);
        check("tmo_block", 64'(GNT), 64'd0);
        m_hang = 1'b0;
        wait_done("tmo_next_done", 3000);
        REQ[1] = 1'b0;
        m_nrd = 0;
        check("tmo_next_status", 64'({d_gnt, d_nack, d_tmo}), 64'b1000);
        check("tmo_next_rd", 64'(rq.size() == 1 ? rq[0] : 8'h00), 64'h77);

        // Slave NACK reported with DONE.
        m_nack = 1'b1;
        start(1, 1'b0, 4'd1, 8'h20);
        wait_done("nack_done", 3000);
        REQ[1] = 1'b0;
        check("nack_status", 64'({d_gnt, d_nack, d_tmo}), 64'b1010);
        repeat (3) @(negedge CLK40);
        m_nack = 1'b0;

        // Reset in the middle of the data phase.
        start(0, 1'b0, 4'd0, 8'h33);
        seq_ok = 1'b0;
        for (int i = 0; i < 200 && !seq_ok; i++) begin
            @(negedge CLK40);
            if (WRT_ENA) seq_ok = 1'b1;
        end
        check("rst_reach_ld_dat", 64'(seq_ok), 64'd1);
        repeat (3) @(negedge CLK40);
        RST_N = 1'b0;
        #1;
        check("rst_mid_outs", outs(), 64'd0);
        REQ = 2'b00;
        repeat (2) @(negedge CLK40);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK40);
        check("rst_after_outs", outs(), 64'd0);

        // Recovery after reset.
        start(1, 1'b0, 4'd1, 8'h44);
        wait_done("post_rst_done", 3000);
        REQ[1] = 1'b0;
        check("post_rst_status", 64'({d_gnt, d_nack, d_tmo}), 64'b1000);

        repeat (5) @(negedge CLK40);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
